// File: rtl/tinynpu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tinynpu_pkg
// Purpose : Shared types and helpers for the tinynpu host sequencer.
//           - seq_state_t : sequencer state encoding (3-bit)
//           - C_CTRL_*    : state codes of the existing NPU control block
//           - lane_lsb()  : LSB position of a lane inside a packed result bus
// Revision: 1.0 - initial release
// ============================================================================
package tinynpu_pkg;

    typedef enum logic [2:0] {
        SEQ_IDLE = 3'd0,
        SEQ_LDX  = 3'd1,
        SEQ_LDW  = 3'd2,
        SEQ_MAC  = 3'd3,
        SEQ_WAIT = 3'd4,
        SEQ_RESP = 3'd5
    } seq_state_t;

    // State codes used by the NPU control block this sequencer talks to.
    localparam logic [1:0] C_CTRL_LD0 = 2'd0;
    localparam logic [1:0] C_CTRL_MAC = 2'd1;
    localparam logic [1:0] C_CTRL_LD1 = 2'd2;
    localparam logic [1:0] C_CTRL_OUT = 2'd3;

    // Lane i of a packed result bus occupies [i*accw +: accw].
    function automatic int unsigned lane_lsb(input int unsigned lane,
                                             input int unsigned accw);
        return lane * accw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tinynpu_lane_cnt.sv
`default_nettype none
// ============================================================================
// Module  : tinynpu_lane_cnt
// Purpose : Nested word/lane counter for weight loading. Counts DEPTH words
//           per lane, then advances to the next lane; reports the last word
//           of the last lane as a terminal count.
// Ports   : clk, rst (async, active-low)
//           en   - one weight word transferred this cycle
//           clr  - synchronous clear of word and lane counts
//           lane - currently selected weight lane
//           tc   - current word is the last word of the last lane
// Revision: 1.0 - initial release
// ============================================================================
module tinynpu_lane_cnt #(
    parameter int SIZE  = 4,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    clr,
    output logic [$clog2(SIZE)-1:0] lane,
    output logic                    tc
);

    localparam int LW = $clog2(SIZE);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] r_wcnt;
    logic [LW-1:0] r_lane;
    logic          w_last_word;

    assign w_last_word = (r_wcnt == CW'(DEPTH - 1));
    assign tc          = w_last_word && (r_lane == LW'(SIZE - 1));
    assign lane        = r_lane;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wcnt <= '0;
            r_lane <= '0;
        end else if (clr) begin
            r_wcnt <= '0;
            r_lane <= '0;
        end else if (en) begin
            if (tc) begin
                // Explicit wrap keeps non-power-of-two SIZE correct.
                r_wcnt <= '0;
                r_lane <= '0;
            end else if (w_last_word) begin
                r_wcnt <= '0;
                r_lane <= r_lane + 1'b1;
            end else begin
                r_wcnt <= r_wcnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tinynpu_host_seq.sv
`default_nettype none
// ============================================================================
// Module  : tinynpu_host_seq
// Purpose : Host-side sequencer for the tinynpu control block. Takes one job
//           as a word stream (DEPTH x words, then SIZE*DEPTH w words in
//           lane-major order), issues x loads, lane-selected w loads and a
//           MAC start, waits for the output stream and returns the result.
// Ports   : clk, rst (async, active-low)
//           in_val/in_rdy/in_data          - host job word stream
//           d2c_*                           - load / MAC commands to the NPU
//           c2d_x_fifo_wen, c2d_w_fifo_wen  - load acceptance from the NPU
//           c2d_ostream_req/_data           - NPU result stream
//           res_val/res_rdy/res_data        - result vector to the host
//           busy, err_timeout               - status
// Revision: 1.0 - initial release
// ============================================================================
module tinynpu_host_seq
    import tinynpu_pkg::*;
#(
    parameter int SIZE    = 4,
    parameter int DEPTH   = 4,
    parameter int DW      = 8,
    parameter int ACCW    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_val,
    output logic                    in_rdy,
    input  logic [DW-1:0]           in_data,
    output logic                    d2c_x_load_val,
    output logic                    d2c_w_load_val,
    output logic [$clog2(SIZE)-1:0] d2c_w_load_sel,
    output logic [DW-1:0]           d2c_load_data,
    output logic                    d2c_mac_val,
    input  logic                    c2d_x_fifo_wen,
    input  logic [SIZE-1:0]         c2d_w_fifo_wen,
    input  logic                    c2d_ostream_req,
    input  logic [SIZE*ACCW-1:0]    c2d_ostream_data,
    output logic                    res_val,
    input  logic                    res_rdy,
    output logic [SIZE*ACCW-1:0]    res_data,
    output logic                    busy,
    output logic                    err_timeout
);

    localparam int LW = $clog2(SIZE);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [CW-1:0]       r_xcnt;
    logic [TW-1:0]       r_tcnt;
    logic [SIZE*ACCW-1:0] r_res;
    logic                r_err;

    logic [LW-1:0]       w_lane;
    logic                w_lane_tc;
    logic                w_lane_clr;
    logic                w_x_xfer;
    logic                w_w_xfer;
    logic                w_x_last;
    logic                w_tmo;
    logic                w_rdy;

    // ------------------------------------------------------------------
    // Transfer qualifiers: a word moves only when the host offers it and
    // the targeted NPU FIFO accepts it in the same cycle.
    // ------------------------------------------------------------------
    assign w_x_xfer   = (r_state == SEQ_LDX) && in_val && c2d_x_fifo_wen;
    assign w_w_xfer   = (r_state == SEQ_LDW) && in_val && c2d_w_fifo_wen[w_lane];
    assign w_x_last   = (r_xcnt == CW'(DEPTH - 1));
    // The cycle in which tcnt would step onto TIMEOUT is the last WAIT cycle.
    assign w_tmo      = (r_tcnt == TW'(TIMEOUT - 1));
    assign w_lane_clr = (r_state == SEQ_RESP) && res_rdy;

    tinynpu_lane_cnt #(
        .SIZE  (SIZE),
        .DEPTH (DEPTH)
    ) u_lane_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (w_w_xfer),
        .clr  (w_lane_clr),
        .lane (w_lane),
        .tc   (w_lane_tc)
    );

    // ------------------------------------------------------------------
    // Next state and command outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_rdy          = 1'b0;
        d2c_x_load_val = 1'b0;
        d2c_w_load_val = 1'b0;
        d2c_load_data  = '0;
        d2c_mac_val    = 1'b0;
        case (r_state)
            SEQ_IDLE: begin
                w_rdy = 1'b1;
                // The first word is only observed here; it is loaded in LDX.
                if (in_val) begin
                    w_state_nxt = SEQ_LDX;
                end
            end
            SEQ_LDX: begin
                d2c_x_load_val = in_val;
                d2c_load_data  = in_data;
                w_rdy          = c2d_x_fifo_wen;
                if (w_x_xfer && w_x_last) begin
                    w_state_nxt = SEQ_LDW;
                end
            end
            SEQ_LDW: begin
                d2c_w_load_val = in_val;
                d2c_load_data  = in_data;
                w_rdy          = c2d_w_fifo_wen[w_lane];
                if (w_w_xfer && w_lane_tc) begin
                    w_state_nxt = SEQ_MAC;
                end
            end
            SEQ_MAC: begin
                d2c_mac_val = 1'b1;
                w_state_nxt = SEQ_WAIT;
            end
            SEQ_WAIT: begin
                // A request in the final timeout cycle still wins.
                if (c2d_ostream_req) begin
                    w_state_nxt = SEQ_RESP;
                end else if (w_tmo) begin
                    w_state_nxt = SEQ_IDLE;
                end
            end
            SEQ_RESP: begin
                if (res_rdy) begin
                    w_state_nxt = SEQ_IDLE;
                end
            end
            default: begin
                w_state_nxt = SEQ_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xcnt <= '0;
        end else if (w_x_xfer) begin
            r_xcnt <= w_x_last ? '0 : r_xcnt + 1'b1;
        end
    end

    // tcnt restarts from zero whenever WAIT is left, so each job gets the
    // full TIMEOUT window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tcnt <= '0;
        end else if (r_state == SEQ_WAIT) begin
            r_tcnt <= (c2d_ostream_req || w_tmo) ? '0 : r_tcnt + 1'b1;
        end
    end

    // Captured only from WAIT, so a late request during RESP cannot
    // overwrite the vector the host is still reading.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_res <= '0;
        end else if ((r_state == SEQ_WAIT) && c2d_ostream_req) begin
            r_res <= c2d_ostream_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if ((r_state == SEQ_WAIT) && !c2d_ostream_req && w_tmo) begin
            r_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. in_rdy is gated by rst because IDLE drives it high and the
    // port must read 0 for the whole time reset is held.
    // ------------------------------------------------------------------
    assign in_rdy         = rst && w_rdy;
    assign d2c_w_load_sel = w_lane;
    assign res_val        = (r_state == SEQ_RESP);
    assign res_data       = r_res;
    assign busy           = (r_state != SEQ_IDLE);
    assign err_timeout    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tinynpu_host_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_tinynpu_host_seq
// Purpose : Self-checking bench for tinynpu_host_seq. A phase-level model of
//           the job protocol predicts every output each cycle; loaded words
//           are collected per target FIFO and compared with the job stream.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tinynpu_host_seq;

    localparam int SIZE    = 4;
    localparam int DEPTH   = 4;
    localparam int DW      = 8;
    localparam int ACCW    = 32;
    localparam int TIMEOUT = 8;
    localparam int NW      = DEPTH + SIZE * DEPTH;
    localparam int RW      = SIZE * ACCW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_val = 1'b0;
    logic              in_rdy;
    logic [DW-1:0]     in_data = '0;
    logic              d2c_x_load_val;
    logic              d2c_w_load_val;
    logic [1:0]        d2c_w_load_sel;
    logic [DW-1:0]     d2c_load_data;
    logic              d2c_mac_val;
    logic              c2d_x_fifo_wen = 1'b0;
    logic [SIZE-1:0]   c2d_w_fifo_wen = '0;
    logic              c2d_ostream_req = 1'b0;
    logic [RW-1:0]     c2d_ostream_data = '0;
    logic              res_val;
    logic              res_rdy = 1'b0;
    logic [RW-1:0]     res_data;
    logic              busy;
    logic              err_timeout;

    always #5 clk = ~clk;

    tinynpu_host_seq #(
        .SIZE    (SIZE),
        .DEPTH   (DEPTH),
        .DW      (DW),
        .ACCW    (ACCW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_val           (in_val),
        .in_rdy           (in_rdy),
        .in_data          (in_data),
        .d2c_x_load_val   (d2c_x_load_val),
        .d2c_w_load_val   (d2c_w_load_val),
        .d2c_w_load_sel   (d2c_w_load_sel),
        .d2c_load_data    (d2c_load_data),
        .d2c_mac_val      (d2c_mac_val),
        .c2d_x_fifo_wen   (c2d_x_fifo_wen),
        .c2d_w_fifo_wen   (c2d_w_fifo_wen),
        .c2d_ostream_req  (c2d_ostream_req),
        .c2d_ostream_data (c2d_ostream_data),
        .res_val          (res_val),
        .res_rdy          (res_rdy),
        .res_data         (res_data),
        .busy             (busy),
        .err_timeout      (err_timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Job protocol phases as seen by the host.
    typedef enum int {P_IDLE, P_LOADX, P_LOADW, P_START, P_WAIT, P_RESP} phase_t;

    phase_t        ph;
    int            m_xdone, m_wc, m_lane, m_wt;
    logic [RW-1:0] m_res;
    logic          m_err;

    logic [DW-1:0] words [NW];
    int            k;
    logic [DW-1:0] seen_x [$];
    logic [DW-1:0] seen_w [SIZE][$];

    task automatic chk(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph = P_IDLE; m_xdone = 0; m_wc = 0; m_lane = 0; m_wt = 0;
        m_res = '0; m_err = 1'b0; k = 0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_rdy"},  in_rdy,         '0);
        chk({tag, "_xval"},    d2c_x_load_val, '0);
        chk({tag, "_wval"},    d2c_w_load_val, '0);
        chk({tag, "_sel"},     d2c_w_load_sel, '0);
        chk({tag, "_ldata"},   d2c_load_data,  '0);
        chk({tag, "_mac"},     d2c_mac_val,    '0);
        chk({tag, "_resval"},  res_val,        '0);
        chk({tag, "_resdata"}, res_data,       '0);
        chk({tag, "_busy"},    busy,           '0);
        chk({tag, "_err"},     err_timeout,    '0);
    endtask

    // Called at a negedge: drive, check predicted outputs, clock, advance model.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic xw,
                         input logic [SIZE-1:0] ww, input logic req,
                         input logic [RW-1:0] od, input logic rr);
        logic e_rdy;
        in_val = v; in_data = d; c2d_x_fifo_wen = xw; c2d_w_fifo_wen = ww;
        c2d_ostream_req = req; c2d_ostream_data = od; res_rdy = rr;
        #1;
        case (ph)
            P_IDLE:  e_rdy = 1'b1;
            P_LOADX: e_rdy = xw;
            P_LOADW: e_rdy = ww[m_lane];
            default: e_rdy = 1'b0;
        endcase
        chk("in_rdy",   in_rdy,         e_rdy);
        chk("x_load",   d2c_x_load_val, (ph == P_LOADX) && v);
        chk("w_load",   d2c_w_load_val, (ph == P_LOADW) && v);
        chk("w_sel",    d2c_w_load_sel, m_lane[1:0]);
        chk("ld_data",  d2c_load_data,  (ph == P_LOADX || ph == P_LOADW) ? d : '0);
        chk("mac_val",  d2c_mac_val,    ph == P_START);
        chk("res_val",  res_val,        ph == P_RESP);
        chk("res_data", res_data,       m_res);
        chk("busy",     busy,           ph != P_IDLE);
        chk("err",      err_timeout,    m_err);
        if (d2c_x_load_val && c2d_x_fifo_wen) seen_x.push_back(d2c_load_data);
        if (d2c_w_load_val && c2d_w_fifo_wen[d2c_w_load_sel])
            seen_w[d2c_w_load_sel].push_back(d2c_load_data);
        @(posedge clk);
        case (ph)
            P_IDLE: if (v) ph = P_LOADX;
            P_LOADX: if (v && xw) begin
                k++; m_xdone++;
                if (m_xdone == DEPTH) begin m_xdone = 0; ph = P_LOADW; end
            end
            P_LOADW: if (v && ww[m_lane]) begin
                k++; m_wc++;
                if (m_wc == DEPTH) begin
                    m_wc = 0; m_lane++;
                    if (m_lane == SIZE) begin m_lane = 0; ph = P_START; end
                end
            end
            P_START: begin ph = P_WAIT; m_wt = 0; end
            P_WAIT: begin
                m_wt++;
                if (req) begin m_res = od; ph = P_RESP; end
                else if (m_wt == TIMEOUT) begin m_err = 1'b1; ph = P_IDLE; end
            end
            P_RESP: if (rr) ph = P_IDLE;
            default: ph = P_IDLE;
        endcase
        @(negedge clk);
    endtask

    // req_at: WAIT cycle (1-based) carrying ostream_req, 0 = never.
    // bp_lane: lane whose wen drops for 3 cycles mid-lane, -1 = none.
    // abort_lane: return early once loading reaches this lane, -1 = never.
    task automatic run_job(input string name, input int req_at, input int bp_lane,
                           input bit gaps, input int abort_lane,
                           input logic [RW-1:0] od_val, output bit aborted);
        int budget; int bp_left; int resp_cyc; bit started;
        logic v, xw, req, rr; logic [SIZE-1:0] ww; logic [RW-1:0] od;
        seen_x.delete();
        for (int s = 0; s < SIZE; s++) seen_w[s].delete();
        k = 0; bp_left = 3; resp_cyc = 0; started = 0; aborted = 0;
        for (budget = 0; budget < 400; budget++) begin
            if (ph == P_LOADW && m_lane == abort_lane) begin aborted = 1; return; end
            if (started && ph == P_IDLE) break;
            v  = (k < NW) && (ph == P_IDLE || ph == P_LOADX || ph == P_LOADW);
            if (gaps && $urandom_range(0, 3) == 0) v = 1'b0;
            xw = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            ww = '1;
            if (ph == P_LOADW && m_lane == bp_lane && m_wc == 1 && bp_left > 0) begin
                ww[bp_lane] = 1'b0; bp_left--;
            end
            req = (ph == P_WAIT) && (m_wt + 1 == req_at);
            od  = od_val;
            if (ph == P_RESP) begin
                resp_cyc++;
                if (resp_cyc == 2) begin req = 1'b1; od = ~od_val; end
            end
            rr = (ph == P_RESP) && (resp_cyc > 4);
            cycle(v, (k < NW) ? words[k] : '0, xw, ww, req, od, rr);
            if (ph != P_IDLE) started = 1;
        end
        chk({name, "_completed"}, budget < 400, 1'b1);
        chk({name, "_x_count"}, seen_x.size(), DEPTH);
        for (int i = 0; i < DEPTH && i < seen_x.size(); i++)
            chk({name, "_x_word"}, seen_x[i], words[i]);
        for (int s = 0; s < SIZE; s++) begin
            chk({name, "_w_count"}, seen_w[s].size(), DEPTH);
            for (int i = 0; i < DEPTH && i < seen_w[s].size(); i++)
                chk({name, "_w_word"}, seen_w[s][i], words[DEPTH + s * DEPTH + i]);
        end
    endtask

    task automatic random_words();
        for (int i = 0; i < NW; i++) words[i] = DW'($urandom);
    endtask

    function automatic logic [RW-1:0] rand_res();
        logic [RW-1:0] r;
        for (int i = 0; i < SIZE; i++) r[i*ACCW +: ACCW] = $urandom;
        return r;
    endfunction

    initial begin
        bit ab;
        logic [RW-1:0] fixed_res;
        model_reset();

        // Reset held with active-looking inputs: every output must stay 0.
        in_val = 1'b1; c2d_x_fifo_wen = 1'b1; c2d_w_fifo_wen = '1;
        #1;
        check_all_zero("por");
        @(negedge clk); @(negedge clk);
        check_all_zero("por_held");
        rst = 1'b1;

        // Directed job: x=1..4, w=0x10..0x1F, result {4,3,2,1} after 5 WAIT cycles.
        for (int i = 0; i < DEPTH; i++) words[i] = DW'(i + 1);
        for (int i = 0; i < SIZE * DEPTH; i++) words[DEPTH + i] = DW'(8'h10 + i);
        fixed_res = {32'h4, 32'h3, 32'h2, 32'h1};
        run_job("job1", 5, -1, 0, -1, fixed_res, ab);
        chk("job1_lane0", res_data[0 +: ACCW], 32'h1);
        chk("job1_lane3", res_data[3*ACCW +: ACCW], 32'h4);

        // Back-pressure on lane 2 and request in the last allowed WAIT cycle.
        random_words();
        run_job("job2", TIMEOUT, 2, 0, -1, rand_res(), ab);
        chk("job2_no_err", err_timeout, 1'b0);

        // No request at all: timeout, back to idle without a result.
        random_words();
        run_job("job3", 0, -1, 0, -1, rand_res(), ab);
        chk("job3_err", err_timeout, 1'b1);

        // Following job still completes, with random gaps on both sides.
        random_words();
        run_job("job4", 3, 1, 1, -1, rand_res(), ab);
        chk("job4_err_sticky", err_timeout, 1'b1);

        // Abort with reset during lane-1 weight loading.
        random_words();
        run_job("job5", 4, -1, 0, 1, rand_res(), ab);
        chk("job5_reached_lane1", ab, 1'b1);
        in_val = 1'b1; c2d_x_fifo_wen = 1'b1; c2d_w_fifo_wen = '1;
        rst = 1'b0;
        #1;
        check_all_zero("mid_rst");
        @(negedge clk);
        check_all_zero("mid_rst_held");
        rst = 1'b1;
        model_reset();

        // Fresh job must start from x word 0.
        random_words();
        run_job("job6", 2, -1, 0, -1, rand_res(), ab);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
